// File: rtl/tx_serial_stream_pkg.sv
// Shared types and constants for the 8b10b serial transmitter.
package tx_serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [8:0]  K28_5  = 9'h1BC;
  localparam int unsigned CODE_W = 10;

endpackage

// File: rtl/tx_serial_stream_encode.sv
// Combinational 8b10b encoder: datain = {K, HGF, EDCBA}; dataout bit 0 = code bit a, bit 9 = code bit j.
module encode_8b10b (
  input  logic [8:0] datain,
  input  logic       dispin,
  output logic [9:0] dataout,
  output logic       dispout
);

  logic [4:0] w_x;
  logic [2:0] w_y;
  logic       w_k;
  logic       w_k28;
  logic [6:0] w_e6;
  logic [5:0] w_t6;
  logic       w_u6;
  logic [5:0] w_six;
  logic       w_rd6;
  logic       w_alt;
  logic [3:0] w_t4;
  logic       w_u4;
  logic       w_comp4;
  logic [3:0] w_four;

  assign w_x   = datain[4:0];
  assign w_y   = datain[7:5];
  assign w_k   = datain[8];
  assign w_k28 = w_k && (w_x == 5'd28);

  // 5b/6b lookup, RD- form as {unbalanced, abcdei}
  always_comb begin
    w_e6 = 7'b0_000000;
    case (w_x)
      5'd0:  w_e6 = 7'b1_100111;
      5'd1:  w_e6 = 7'b1_011101;
      5'd2:  w_e6 = 7'b1_101101;
      5'd3:  w_e6 = 7'b0_110001;
      5'd4:  w_e6 = 7'b1_110101;
      5'd5:  w_e6 = 7'b0_101001;
      5'd6:  w_e6 = 7'b0_011001;
      5'd7:  w_e6 = 7'b0_111000;
      5'd8:  w_e6 = 7'b1_111001;
      5'd9:  w_e6 = 7'b0_100101;
      5'd10: w_e6 = 7'b0_010101;
      5'd11: w_e6 = 7'b0_110100;
      5'd12: w_e6 = 7'b0_001101;
      5'd13: w_e6 = 7'b0_101100;
      5'd14: w_e6 = 7'b0_011100;
      5'd15: w_e6 = 7'b1_010111;
      5'd16: w_e6 = 7'b1_011011;
      5'd17: w_e6 = 7'b0_100011;
      5'd18: w_e6 = 7'b0_010011;
      5'd19: w_e6 = 7'b0_110010;
      5'd20: w_e6 = 7'b0_001011;
      5'd21: w_e6 = 7'b0_101010;
      5'd22: w_e6 = 7'b0_011010;
      5'd23: w_e6 = 7'b1_111010;
      5'd24: w_e6 = 7'b1_110011;
      5'd25: w_e6 = 7'b0_100110;
      5'd26: w_e6 = 7'b0_010110;
      5'd27: w_e6 = 7'b1_110110;
      5'd28: w_e6 = 7'b0_001110;
      5'd29: w_e6 = 7'b1_101110;
      5'd30: w_e6 = 7'b1_011110;
      5'd31: w_e6 = 7'b1_101011;
      default: w_e6 = 7'b0_000000;
    endcase
  end

  // D.07 is balanced but still alternates with disparity
  assign w_u6  = w_k28 ? 1'b1 : w_e6[6];
  assign w_t6  = w_k28 ? 6'b001111 : w_e6[5:0];
  assign w_six = (dispin && (w_u6 || (w_x == 5'd7))) ? ~w_t6 : w_t6;
  assign w_rd6 = dispin ^ w_u6;

  assign w_alt = w_k || (!w_rd6 && ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20)))
                     || (w_rd6 && ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14)));

  // 3b/4b lookup, RD- form as fghj
  always_comb begin
    w_t4 = 4'b0000;
    w_u4 = 1'b0;
    case (w_y)
      3'd0: begin w_t4 = 4'b1011; w_u4 = 1'b1; end
      3'd1: begin w_t4 = w_k ? 4'b0110 : 4'b1001; w_u4 = 1'b0; end
      3'd2: begin w_t4 = w_k ? 4'b1010 : 4'b0101; w_u4 = 1'b0; end
      3'd3: begin w_t4 = 4'b1100; w_u4 = 1'b0; end
      3'd4: begin w_t4 = 4'b1101; w_u4 = 1'b1; end
      3'd5: begin w_t4 = w_k ? 4'b0101 : 4'b1010; w_u4 = 1'b0; end
      3'd6: begin w_t4 = w_k ? 4'b1001 : 4'b0110; w_u4 = 1'b0; end
      3'd7: begin w_t4 = w_alt ? 4'b0111 : 4'b1110; w_u4 = 1'b1; end
      default: begin w_t4 = 4'b0000; w_u4 = 1'b0; end
    endcase
  end

  assign w_comp4 = w_u4 || (w_y == 3'd3)
                 || (w_k && ((w_y == 3'd1) || (w_y == 3'd2) || (w_y == 3'd5) || (w_y == 3'd6)));
  assign w_four  = (w_rd6 && w_comp4) ? ~w_t4 : w_t4;
  assign dispout = w_rd6 ^ w_u4;

  assign dataout = {w_four[0], w_four[1], w_four[2], w_four[3],
                    w_six[0], w_six[1], w_six[2], w_six[3], w_six[4], w_six[5]};

endmodule

// File: rtl/tx_serial_stream.sv
// 8b10b serial transmitter: accepts {K, byte} characters, encodes with running
// disparity and shifts each code group out gap-free, inserting idle commas when starved.
module tx_serial_stream
  import tx_serial_pkg::*;
#(
  parameter int unsigned DVSR_W    = 8,
  parameter bit          MSB_FIRST = 1'b0,
  parameter logic [8:0]  IDLE_CHAR = K28_5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [DVSR_W-1:0] dvsr_i,
  input  logic [8:0]        data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              data_o,
  output logic              bit_stb_o,
  output logic              idle_o,
  output logic              rd_o
);

  state_t              state_q, state_d;
  logic [DVSR_W-1:0]   cnt_q, cnt_d;
  logic [DVSR_W-1:0]   dvsr_q, dvsr_d;
  logic [3:0]          bit_q, bit_d;
  logic [CODE_W-1:0]   shift_q, shift_d;
  logic                rd_q, rd_d;
  logic                idle_q, idle_d;

  logic                w_last_bit;
  logic                w_boundary;
  logic                w_load;
  logic [8:0]          w_char;
  logic [CODE_W-1:0]   w_code;
  logic                w_dispout;
  logic [3:0]          w_idx;

  assign w_last_bit = (cnt_q == dvsr_q) && (bit_q == 4'd9);
  assign w_boundary = (state_q == IDLE) ? en_i : w_last_bit;
  assign w_load     = w_boundary && en_i;
  assign w_char     = valid_i ? data_i : IDLE_CHAR;

  encode_8b10b u_enc (
    .datain  (w_char),
    .dispin  (rd_q),
    .dataout (w_code),
    .dispout (w_dispout)
  );

  // Next-state: load at a character boundary, otherwise advance the bit timer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    dvsr_d  = dvsr_q;
    shift_d = shift_q;
    rd_d    = rd_q;
    idle_d  = idle_q;
    if (w_load) begin
      state_d = RUN;
      shift_d = w_code;
      rd_d    = w_dispout;
      idle_d  = !valid_i;
      dvsr_d  = dvsr_i;
      cnt_d   = {DVSR_W{1'b0}};
      bit_d   = 4'd0;
    end else if (w_boundary) begin
      state_d = IDLE;
      cnt_d   = {DVSR_W{1'b0}};
      bit_d   = 4'd0;
    end else if (state_q == RUN) begin
      if (cnt_q == dvsr_q) begin
        cnt_d = {DVSR_W{1'b0}};
        bit_d = bit_q + 4'd1;
      end else begin
        cnt_d = cnt_q + DVSR_W'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= {DVSR_W{1'b0}};
      bit_q   <= 4'd0;
      dvsr_q  <= {DVSR_W{1'b0}};
      shift_q <= {CODE_W{1'b0}};
      rd_q    <= 1'b0;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      dvsr_q  <= dvsr_d;
      shift_q <= shift_d;
      rd_q    <= rd_d;
      idle_q  <= idle_d;
    end
  end

  // ready is gated by reset so it stays low while reset is held with en_i high
  assign ready_o   = rst_ni && w_load;
  assign w_idx     = MSB_FIRST ? (4'd9 - bit_q) : bit_q;
  assign data_o    = (state_q == RUN) ? shift_q[w_idx] : 1'b0;
  assign bit_stb_o = (state_q == RUN) && (cnt_q == {DVSR_W{1'b0}});
  assign idle_o    = (state_q == RUN) && idle_q;
  assign rd_o      = rd_q;

endmodule

// File: tb/tb_tx_serial_stream.sv
// Scoreboard bench for tx_serial_stream: the driver predicts each code group from
// 8b10b disparity rules; an independent monitor checks every line cycle against it.
module tb_tx_serial_stream;
  import tx_serial_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en_i = 1'b0;
  logic [DW-1:0] dvsr_i = '0;
  logic [8:0]    data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o, data_o, bit_stb_o, idle_o, rd_o;

  always #5 clk = ~clk;

  tx_serial_stream #(.DVSR_W(DW), .MSB_FIRST(1'b0), .IDLE_CHAR(9'h1BC)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .dvsr_i(dvsr_i), .data_i(data_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .bit_stb_o(bit_stb_o),
    .idle_o(idle_o), .rd_o(rd_o)
  );

  typedef struct {
    logic [9:0] line;   // line[k] is the k-th bit on the wire
    logic       idle;
    logic       rd;
    int         per;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // 5b/6b and 3b/4b RD- code tables, a (resp. f) as MSB
  localparam logic [5:0] T6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] T4 [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

  bit m_run = 1'b0;
  int m_left = 0;
  bit m_rd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: unbalanced sub-blocks (and the balanced 111000/1100) flip with RD
  function automatic void ref_enc(input logic [8:0] ch, input bit rd_in,
                                  output logic [9:0] code, output bit rd_out);
    logic [5:0] six;
    logic [3:0] four;
    logic [4:0] x;
    logic [2:0] y;
    bit rd;
    x = ch[4:0];
    y = ch[7:5];
    if (ch == K28_5) begin
      code   = rd_in ? 10'b110000_0101 : 10'b001111_1010;
      rd_out = !rd_in;
    end else begin
      six = T6[x];
      if (rd_in && (($countones(six) != 3) || (six == 6'b111000))) six = ~six;
      rd = rd_in ^ ($countones(six) != 3);
      if (y == 3'd7)
        four = ((!rd && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                (rd && (x == 5'd11 || x == 5'd13 || x == 5'd14))) ? 4'b0111 : 4'b1110;
      else
        four = T4[y];
      if (rd && (($countones(four) != 2) || (four == 4'b1100))) four = ~four;
      rd_out = rd ^ ($countones(four) != 2);
      code   = {six, four};
    end
  endfunction

  task automatic drive_now(input bit en, input bit v, input logic [8:0] d, input logic [DW-1:0] dv);
    bit          bnd, exp_rdy, nrd;
    logic [9:0]  code;
    exp_t        e;
    en_i = en; valid_i = v; data_i = d; dvsr_i = dv;
    #1;
    bnd     = !m_run || (m_left == 0);
    exp_rdy = en && bnd;
    chk("ready", ready_o, exp_rdy);
    if (exp_rdy) begin
      ref_enc(v ? d : K28_5, m_rd, code, nrd);
      for (int k = 0; k < 10; k++) e.line[k] = code[9-k];
      e.idle = !v;
      e.rd   = nrd;
      e.per  = int'(dv) + 1;
      sb.push_back(e);
      m_rd   = nrd;
      m_run  = 1'b1;
      m_left = 10 * (int'(dv) + 1) - 1;
    end else if (m_run && m_left == 0) begin
      m_run = 1'b0;
    end else if (m_run) begin
      m_left--;
    end
  endtask

  task automatic drive_cycle(input bit en, input bit v, input logic [8:0] d, input logic [DW-1:0] dv);
    @(negedge clk);
    drive_now(en, v, d, dv);
  endtask

  task automatic reset_mid_char();
    @(negedge clk);
    #3 rst_ni = 1'b0;
    #1;
    chk("rst_data", data_o, 1'b0);
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_stb", bit_stb_o, 1'b0);
    chk("rst_rd", rd_o, 1'b0);
    chk("rst_idle", idle_o, 1'b0);
    en_i = 1'b0; valid_i = 1'b0;
    sb.delete();
    m_run = 1'b0; m_left = 0; m_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_ni = 1'b1;
    #1 chk("rd_before_load", rd_o, 1'b0);
  endtask

  // Monitor: pops a group at its first strobe and checks every clock of it
  initial begin : monitor
    bit   in_grp;
    int   cyc;
    exp_t cur;
    in_grp = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        in_grp = 1'b0;
      end else begin
        if (!in_grp) begin
          if (bit_stb_o) begin
            if (sb.size() == 0) begin
              chk("unexpected_group", 32'd1, 32'd0);
            end else begin
              cur = sb.pop_front();
              in_grp = 1'b1;
              cyc = 0;
              chk("idle_flag", idle_o, cur.idle);
              chk("rd_after", rd_o, cur.rd);
            end
          end else if (sb.size() != 0) begin
            chk("gap", 32'd1, 32'd0);
          end else begin
            chk("line_idle", data_o, 1'b0);
          end
        end
        if (in_grp) begin
          chk("line_bit", data_o, cur.line[cyc / cur.per]);
          chk("bit_stb", bit_stb_o, (cyc % cur.per) == 0);
          cyc++;
          if (cyc == 10 * cur.per) in_grp = 1'b0;
        end
      end
    end
  end

  initial begin : driver
    logic [8:0] ch;
    en_i = 1'b1; valid_i = 1'b1; data_i = 9'h0B5; dvsr_i = '0;
    repeat (3) @(negedge clk);
    chk("hold_data", data_o, 1'b0);
    chk("hold_ready", ready_o, 1'b0);
    chk("hold_rd", rd_o, 1'b0);

    // release with idle commas at one clock per bit
    @(negedge clk);
    rst_ni = 1'b1;
    drive_now(1'b1, 1'b0, 9'h000, 8'd0);
    repeat (24) drive_cycle(1'b1, 1'b0, 9'h000, 8'd0);

    repeat (90) drive_cycle(1'b1, 1'b1, 9'h0B5, 8'd3);

    // divider change mid-character
    repeat (15) drive_cycle(1'b1, 1'b1, 9'h0B5, 8'd3);
    repeat (60) drive_cycle(1'b1, 1'b1, 9'h0F1, 8'd1);

    // enable drop at bit 4, then re-enable
    repeat (45) drive_cycle(1'b0, 1'b0, 9'h000, 8'd3);
    drive_cycle(1'b1, 1'b1, 9'h07E, 8'd3);
    repeat (17) drive_cycle(1'b1, 1'b1, 9'h0E7, 8'd3);
    repeat (60) drive_cycle(1'b0, 1'b1, 9'h0E7, 8'd3);
    repeat (25) drive_cycle(1'b1, 1'b1, 9'h0E7, 8'd0);

    reset_mid_char();
    repeat (30) drive_cycle(1'b1, 1'b0, 9'h000, 8'd0);

    for (int i = 0; i < 2500; i++) begin
      ch = ($urandom_range(0, 7) == 0) ? K28_5 : {1'b0, 8'($urandom)};
      drive_cycle($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, ch,
                  8'($urandom_range(0, 3)));
    end

    repeat (50) drive_cycle(1'b0, 1'b0, 9'h000, 8'd0);
    chk("drain", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_serial_stream.md
Name: tx_serial_stream

Overview:
Parametrised 8b10b serial transmitter: accepts 9-bit characters ({K flag, byte}) over a valid/ready handshake and encodes each with running disparity. Each 10-bit code group is shifted out one bit per (dvsr+1) clocks with no gaps. When no data is offered at a character boundary, the block inserts an idle comma, so the line never stalls. Sits between the packet/framing logic and the serial pad driver.

Parameters:
DVSR_W, 8, width of the bit-period divider input; bit period is 1..2^DVSR_W clocks.
MSB_FIRST, 0, 0: code bit 0 (a) sent first; 1: code bit 9 (j) sent first.
IDLE_CHAR, 9'h1BC, character encoded when no data is accepted (K28.5; bit 8 = K flag).

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
en_i  in  1  transmitter enable
dvsr_i  in  DVSR_W  bit period minus one, in clocks
data_i  in  9  {K, byte} character to send
valid_i  in  1  data_i valid
ready_o  out  1  character accepted this cycle when valid_i=1
data_o  out  1  serial line
bit_stb_o  out  1  pulse in the first clock of every transmitted bit
idle_o  out  1  high while the current code group is IDLE_CHAR inserted by the block
rd_o  out  1  running disparity after the current code group (0 = RD-, 1 = RD+)

Behaviour:
- Reset (rst_ni=0, async): state IDLE; counters=0; shift reg=0; rd=0; data_o=0, ready_o=0, bit_stb_o=0, idle_o=0, rd_o=0 immediately.
- FSM with states IDLE and RUN. Registers: cnt_q[DVSR_W], bit_q[3:0], dvsr_q, shift_q[9:0], rd_q, idle_q.
- Boundary cycle is one of: (a) IDLE with en_i=1; (b) RUN with cnt_q==dvsr_q && bit_q==9.
- ready_o = en_i in a boundary cycle, else 0. It is combinational from en_i and state, never from valid_i.
- Load, in a boundary cycle with en_i=1:
  - If valid_i, encode data_i and set idle_q=0.
  - Otherwise encode IDLE_CHAR and set idle_q=1.
  - shift_q gets the code group; rd_q gets the encoder's dispout; dvsr_q gets dvsr_i; cnt_q=0, bit_q=0; state goes to RUN.
- Latency: the first bit appears on data_o in the clock after acceptance.
- In RUN, cnt_q increments each clock. At cnt_q==dvsr_q, cnt_q resets to 0 and bit_q increments.
- data_o = shift_q[bit_q] (MSB_FIRST=0) or shift_q[9-bit_q] (MSB_FIRST=1); it is 0 in IDLE.
- bit_stb_o = (state==RUN && cnt_q==0).
- A boundary cycle with en_i=0 moves the FSM to IDLE. An en_i drop mid-character never truncates that character.
- Character period is exactly 10*(dvsr_q+1) clocks, with back-to-back code groups and no gap cycles.
- dvsr_i changes take effect only at the next load. dvsr_i=0 gives one clock per bit.
- The encoder input disparity is always rd_q, and disparity advances on idle characters too.
- Invalid K codes are passed to the encoder unchanged; the result is undefined and is not checked.
- valid_i high with ready_o low: data_i is not consumed. The source must hold it.

Decomposition:
- Package tx_serial_pkg: state enum (IDLE, RUN), K28_5 constant (9'h1BC), code-group width constant 10.
- Sub-module: reuse the existing encode_8b10b, one instance (datain, dispin=rd_q, dataout, dispout).
- Everything else lives in this module.

Test Plan:
- Reset held, en_i=1, valid_i=1 -> data_o=0, ready_o=0. Release with en_i=1 -> ready_o=1 in the first clock, bits start in the next clock.
- dvsr_i=0, valid_i=0 -> first group is K28.5 RD- with line sequence 0,0,1,1,1,1,1,0,1,0, idle_o=1, rd_o=1. Second group is K28.5 RD+ 1,1,0,0,0,0,0,1,0,1, and rd_o returns to 0.
- dvsr_i=3, valid_i held with data_i=9'h0B5 (D21.5) -> each bit held 4 clocks, ready_o pulses every 40 clocks, line 1,0,1,0,1,0,1,0,1,0, rd_o unchanged, idle_o=0.
- dvsr_i switched 3->1 mid-character -> current group keeps 4 clocks/bit and the next group uses 2 clocks/bit. bit_stb_o count = 10 per group.
- en_i dropped at bit 4 -> group completes all 10 bits, then data_o=0 and ready_o=0. Re-enable -> ready_o=1 next clock.
- rst_ni pulsed low mid-character -> data_o=0 asynchronously. After release, the first group uses RD- (rd_o=0 before load).
